// File: rtl/pipeline_sched.sv
// ---------------------------------------------------------------------------
// pipeline_sched
//
// Shares one pipelined processing stage between N_CH sample channels.
// Each channel holds one sample and a pending bit. A round-robin arbiter
// issues one pending sample per cycle to the stage. The channel index of
// every issue is kept in a tag FIFO, so results go back to the owning
// channel strictly in issue order.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   ch_en           per-channel input strobe
//   ch_sample_i     per-channel input sample, channel k at [32k+31:32k]
//   ch_valid        per-channel one-cycle result strobe
//   ch_sample_o     per-channel result, held between strobes
//   ch_overrun      sticky per-channel overrun flag
//   stage_en        issue strobe to the shared stage
//   stage_sample_i  sample issued to the stage
//   stage_ready     stage accepts an issue while high
//   stage_valid     stage result strobe
//   stage_sample_o  stage result
//   tag_err         sticky: stage result arrived with nothing in flight
// ---------------------------------------------------------------------------
module pipeline_sched #(
    parameter int N_CH      = 4,
    parameter int TAG_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      ch_en,
    input  logic [32*N_CH-1:0]   ch_sample_i,
    output logic [N_CH-1:0]      ch_valid,
    output logic [32*N_CH-1:0]   ch_sample_o,
    output logic [N_CH-1:0]      ch_overrun,
    output logic                 stage_en,
    output logic [31:0]          stage_sample_i,
    input  logic                 stage_ready,
    input  logic                 stage_valid,
    input  logic [31:0]          stage_sample_o,
    output logic                 tag_err
);

    localparam int TAG_W = $clog2(N_CH);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Channel index reached by stepping off positions up from base, with wrap.
    function automatic logic [TAG_W-1:0] wrap_idx(input int base, input int off);
        return TAG_W'((base + off) % N_CH);
    endfunction

    logic [31:0]        held_r [N_CH];
    logic [N_CH-1:0]    pending_r;
    logic [N_CH-1:0]    overrun_r;
    logic [TAG_W-1:0]   rr_ptr_r;

    logic [TAG_W-1:0]   tag_mem_r [TAG_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic               stage_en_r;
    logic [31:0]        stage_sample_r;
    logic [N_CH-1:0]    ch_valid_r;
    logic [32*N_CH-1:0] ch_sample_r;
    logic               tag_err_r;

    logic               grant_s;
    logic [TAG_W-1:0]   grant_idx_s;
    logic               issue_s;
    logic               pop_s;
    logic [TAG_W-1:0]   head_tag_s;

    // Round-robin search for the first pending channel at or above rr_ptr.
    always_comb begin
        grant_s     = 1'b0;
        grant_idx_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!grant_s && pending_r[wrap_idx(int'(rr_ptr_r), i)]) begin
                grant_s     = 1'b1;
                grant_idx_s = wrap_idx(int'(rr_ptr_r), i);
            end else begin
                grant_s     = grant_s;
                grant_idx_s = grant_idx_s;
            end
        end
    end

    // A full count blocks issue even when a result pops in the same cycle.
    assign issue_s    = grant_s && stage_ready && (count_r < CNT_W'(TAG_DEPTH));
    assign pop_s      = stage_valid && (count_r != '0);
    assign head_tag_s = tag_mem_r[rd_ptr_r];

    // Per-channel holding registers, pending bits and sticky overrun flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_r <= '0;
            overrun_r <= '0;
            for (int k = 0; k < N_CH; k++) begin
                held_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (ch_en[k]) begin
                    held_r[k]    <= ch_sample_i[32*k +: 32];
                    pending_r[k] <= 1'b1;
                    // A reload in the issuing cycle replaces nothing unread.
                    if (pending_r[k] && !(issue_s && (grant_idx_s == TAG_W'(k)))) begin
                        overrun_r[k] <= 1'b1;
                    end
                end else if (issue_s && (grant_idx_s == TAG_W'(k))) begin
                    pending_r[k] <= 1'b0;
                end
            end
        end
    end

    // Registered issue to the stage and round-robin pointer advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_en_r     <= 1'b0;
            stage_sample_r <= '0;
            rr_ptr_r       <= '0;
        end else begin
            stage_en_r <= issue_s;
            if (issue_s) begin
                stage_sample_r <= held_r[grant_idx_s];
                rr_ptr_r       <= (grant_idx_s == TAG_W'(N_CH - 1)) ? '0 : grant_idx_s + TAG_W'(1);
            end
        end
    end

    // Tag FIFO: pushed on issue, popped on a result; pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int d = 0; d < TAG_DEPTH; d++) begin
                tag_mem_r[d] <= '0;
            end
        end else begin
            if (issue_s) begin
                tag_mem_r[wr_ptr_r] <= grant_idx_s;
                wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({issue_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Route each stage result to the channel at the FIFO head; flag orphans.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_valid_r  <= '0;
            ch_sample_r <= '0;
            tag_err_r   <= 1'b0;
        end else begin
            ch_valid_r <= '0;
            if (stage_valid && (count_r == '0)) begin
                tag_err_r <= 1'b1;
            end
            for (int k = 0; k < N_CH; k++) begin
                if (pop_s && (head_tag_s == TAG_W'(k))) begin
                    ch_valid_r[k]             <= 1'b1;
                    ch_sample_r[32*k +: 32]   <= stage_sample_o;
                end
            end
        end
    end

    assign stage_en       = stage_en_r;
    assign stage_sample_i = stage_sample_r;
    assign ch_valid       = ch_valid_r;
    assign ch_sample_o    = ch_sample_r;
    assign ch_overrun     = overrun_r;
    assign tag_err        = tag_err_r;

endmodule
